map_row_rmw_writer: RTL and testbench
=====================================

# map_row_rmw_writer

Read-modify-write engine for port B of the 30-row × 160-bit tile map RAM. Sits downstream of the pacman and ghost location controllers and upstream of the map RAM. It accepts move requests (current tile, next tile) from three agents and arbitrates between them. It rewrites the affected map rows so the VGA path on port A renders the new positions.

## Interface
- RD_LAT, 2: map RAM port-B read latency in cycles, from address to valid q; legal values 1–3.
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req  in  3  move request, level, held until `done`; bit0 pacman, bit1 ghost1, bit2 ghost2.
- cur_x  in  3×6  current tile column per agent, 0–39.
- cur_y  in  3×5  current tile row per agent, 0–29.
- nxt_x  in  3×6  requested tile column per agent.
- nxt_y  in  3×5  requested tile row per agent.
- done  out  3  one-cycle pulse to the agent whose request finished.
- rejected  out  1  valid with `done`; 1 = map unchanged.
- busy  out  1  high in every state except IDLE.
- ram_addr  out  5  port-B address, used for both read and write.
- ram_wren  out  1  port-B write enable.
- ram_wdata  out  160  port-B write data.
- ram_rdata  in  160  port-B read data.

## Operation
- Tile x of a row occupies bits [159-4x : 156-4x], so column 0 is in the MSBs.
- Tile codes: EMPTY=0, WALL=1, PILL=2, PACMAN=3, GHOST1=4, GHOST2=5. Object code per agent: 3, 4, 5.
- Arbitration in IDLE uses fixed priority: pacman > ghost1 > ghost2.
  - Operands of the granted agent are latched on acceptance.
  - Later input changes are ignored.
- States:
  - IDLE: wait for a request.
  - RD_NXT: drive ram_addr = nxt_y for RD_LAT cycles.
  - WR_NXT: write the next row with the object code inserted. For a ghost, first capture the old next tile into that ghost's `under` register.
  - RD_CUR: drive ram_addr = cur_y for RD_LAT cycles.
  - WR_CUR: write the current row with the restore tile inserted.
  - DONE: pulse `done`, then return to IDLE.
- Restore tile:
  - pacman always restores EMPTY, because the pill is eaten.
  - A ghost restores its previous `under` value.
- `under` update: if the captured tile is an agent code (3–5), store EMPTY instead.
- Immediate reject, IDLE→DONE with rejected=1, when any of:
  - a coordinate is out of range (x>39 or y>29);
  - cur == nxt;
  - |dx|+|dy| ≠ 1 (only single-step moves are legal).
- Wall reject: if the next tile is WALL at the end of RD_NXT, go RD_NXT→DONE with rejected=1. No writes occur and `under` is unchanged.
- Same-row move (cur_y == nxt_y): RD_CUR reads back the row written in WR_NXT. The RAM must be configured for new-data read-during-write so that both edits persist.

## Timing
- Acceptance edge = cycle 0. Normal path:
  - RD_NXT: cycles 1..RD_LAT.
  - WR_NXT: cycle RD_LAT+1.
  - RD_CUR: cycles RD_LAT+2..2·RD_LAT+1.
  - WR_CUR: cycle 2·RD_LAT+2.
  - `done`: cycle 2·RD_LAT+3, i.e. cycle 7 at the default RD_LAT.
- Immediate reject: `done` in cycle 1. Wall reject: `done` in cycle RD_LAT+1.
- `ram_wren` is high for exactly one cycle each in WR_NXT and WR_CUR, and 0 otherwise.
- Requester must drop `req` by the edge that ends its `done` cycle. A `req` seen in IDLE is always a new request.
- A request arriving while busy waits. It is granted in the first IDLE cycle, subject to priority.
- Reset values: done=0, rejected=0, busy=0, ram_wren=0, ram_addr=0, ram_wdata=0, state=IDLE, both `under`=EMPTY.
- Reset asserted mid-operation: `ram_wren` drops immediately (asynchronous) and no `done` is issued. A half-written move is left as-is; the top level reloads the map on reset.

## Structure
- Shared package `pacman_pkg`:
  - tile-code constants;
  - MAP_COLS=40 and MAP_ROWS=30;
  - agent index enum (PAC, G1, G2);
  - functions `tile_get(row, x)` and `tile_set(row, x, code)` using the MSB-first mapping.
- One combinational sub-module, `map_row_patch`: input row, x, code; outputs the patched row and the old tile.
- The FSM, arbiter, latency counter and `under` registers live in the top.

## Test plan
- Pacman (20,20)→(21,20), row 20 holds PILL at x=21: one write to row 20 with x=21=3 and x=20=0; done[0] at cycle 7; rejected=0.
- Ghost1 (16,13)→(16,12), where (16,12)=PILL: row 12 x=16 becomes 4 and row 13 x=16 becomes 0. Then ghost1 (16,12)→(16,13): row 12 x=16 is restored to 2.
- Pacman next tile is WALL: no `ram_wren` pulse; done[0] with rejected=1 at cycle 3; map unchanged.
- req=3'b111 simultaneously: grants in order pacman, ghost1, ghost2. Each `done` is 8 cycles after the previous (7-cycle op + IDLE). Inspect the final rows.
- Out-of-range nxt_x=40, a diagonal move, and cur==nxt: each gives `done` at cycle 1 with rejected=1 and no writes.
- Reset asserted during WR_NXT: `ram_wren` goes low asynchronously, all outputs are 0, no `done`. A fresh request after release completes normally.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared tile-map definitions: tile codes, map geometry, agent indices and
// MSB-first row accessors (column 0 lives in the top nibble of a row).
package pacman_pkg;
    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;
    localparam int TILE_W   = 4;
    localparam int ROW_W    = MAP_COLS * TILE_W;

    typedef enum logic [3:0] {
        T_EMPTY  = 4'd0,
        T_WALL   = 4'd1,
        T_PILL   = 4'd2,
        T_PACMAN = 4'd3,
        T_GHOST1 = 4'd4,
        T_GHOST2 = 4'd5
    } tile_t;

    typedef enum logic [1:0] {
        PAC = 2'd0,
        G1  = 2'd1,
        G2  = 2'd2
    } agent_t;

    function automatic logic [TILE_W-1:0] tile_get(input logic [ROW_W-1:0] row,
                                                   input logic [5:0]       x);
        logic [TILE_W-1:0] t;
        t = T_EMPTY;
        for (int i = 0; i < MAP_COLS; i++)
            if (x == 6'(i)) t = row[ROW_W-1-TILE_W*i -: TILE_W];
        return t;
    endfunction

    function automatic logic [ROW_W-1:0] tile_set(input logic [ROW_W-1:0]  row,
                                                  input logic [5:0]        x,
                                                  input logic [TILE_W-1:0] code);
        logic [ROW_W-1:0] r;
        r = row;
        for (int i = 0; i < MAP_COLS; i++)
            if (x == 6'(i)) r[ROW_W-1-TILE_W*i -: TILE_W] = code;
        return r;
    endfunction

    function automatic logic [TILE_W-1:0] agent_code(input agent_t a);
        logic [TILE_W-1:0] c;
        case (a)
            PAC:     c = T_PACMAN;
            G1:      c = T_GHOST1;
            default: c = T_GHOST2;
        endcase
        return c;
    endfunction

    function automatic logic is_agent_code(input logic [TILE_W-1:0] t);
        return (t == T_PACMAN) || (t == T_GHOST1) || (t == T_GHOST2);
    endfunction

    // In range, and exactly one orthogonal step (which also excludes cur == nxt).
    function automatic logic move_ok(input logic [5:0] cx, input logic [4:0] cy,
                                     input logic [5:0] nx, input logic [4:0] ny);
        logic [5:0] adx;
        logic [4:0] ady;
        adx = (nx > cx) ? nx - cx : cx - nx;
        ady = (ny > cy) ? ny - cy : cy - ny;
        return (cx < 6'(MAP_COLS)) && (nx < 6'(MAP_COLS)) &&
               (cy < 5'(MAP_ROWS)) && (ny < 5'(MAP_ROWS)) &&
               (((adx == 6'd1) && (ady == 5'd0)) || ((adx == 6'd0) && (ady == 5'd1)));
    endfunction
endpackage

// File: rtl/map_row_patch.sv
// Combinational single-tile patch of one map row; also reports the tile it replaced.
module map_row_patch
    import pacman_pkg::*;
(
    input  logic [ROW_W-1:0]  row,
    input  logic [5:0]        x,
    input  logic [TILE_W-1:0] code,
    output logic [ROW_W-1:0]  patched,
    output logic [TILE_W-1:0] old
);
    assign patched = tile_set(row, x, code);
    assign old     = tile_get(row, x);
endmodule

// File: rtl/map_row_rmw_writer.sv
// Port-B read-modify-write engine for the tile map: arbitrates agent moves and
// rewrites the next-tile row, then the current-tile row.
module map_row_rmw_writer
    import pacman_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [2:0]           req,
    input  logic [2:0][5:0]      cur_x,
    input  logic [2:0][4:0]      cur_y,
    input  logic [2:0][5:0]      nxt_x,
    input  logic [2:0][4:0]      nxt_y,
    output logic [2:0]           done,
    output logic                 rejected,
    output logic                 busy,
    output logic [4:0]           ram_addr,
    output logic                 ram_wren,
    output logic [ROW_W-1:0]     ram_wdata,
    input  logic [ROW_W-1:0]     ram_rdata
);
    typedef enum logic [2:0] {IDLE, RD_NXT, WR_NXT, RD_CUR, WR_CUR, DONE} state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t              state_reg, state_next;
    logic [1:0]          lat_reg, lat_next;
    agent_t              agent_reg, agent_next;
    logic [5:0]          cx_reg, cx_next, nx_reg, nx_next;
    logic [4:0]          cy_reg, cy_next, ny_reg, ny_next;
    logic [1:0][3:0]     under_reg, under_next;   // [0] ghost1, [1] ghost2
    logic [3:0]          nxt_old_reg, nxt_old_next;
    logic [2:0]          done_reg, done_next;
    logic                rejected_reg, rejected_next;
    logic                busy_reg, busy_next;
    logic [4:0]          ram_addr_reg, ram_addr_next;
    logic                ram_wren_reg, ram_wren_next;
    logic [ROW_W-1:0]    ram_wdata_reg, ram_wdata_next;

    agent_t              grant;
    logic [5:0]          in_cx, in_nx;
    logic [4:0]          in_cy, in_ny;
    logic [3:0]          restore;
    logic [5:0]          patch_x;
    logic [3:0]          patch_code;
    logic [ROW_W-1:0]    patch_row;
    logic [3:0]          patch_old;

    always_comb begin
        grant = PAC;
        if (!req[0]) grant = req[1] ? G1 : G2;
        case (grant)
            PAC: begin
                in_cx = cur_x[0]; in_cy = cur_y[0]; in_nx = nxt_x[0]; in_ny = nxt_y[0];
            end
            G1: begin
                in_cx = cur_x[1]; in_cy = cur_y[1]; in_nx = nxt_x[1]; in_ny = nxt_y[1];
            end
            default: begin
                in_cx = cur_x[2]; in_cy = cur_y[2]; in_nx = nxt_x[2]; in_ny = nxt_y[2];
            end
        endcase
    end

    // Pacman eats whatever it stood on; ghosts put back what they covered.
    always_comb begin
        case (agent_reg)
            PAC:     restore = T_EMPTY;
            G1:      restore = under_reg[0];
            default: restore = under_reg[1];
        endcase
    end

    assign patch_x    = (state_reg == RD_CUR) ? cx_reg : nx_reg;
    assign patch_code = (state_reg == RD_CUR) ? restore : agent_code(agent_reg);

    map_row_patch u_patch (
        .row     (ram_rdata),
        .x       (patch_x),
        .code    (patch_code),
        .patched (patch_row),
        .old     (patch_old)
    );

    always_comb begin
        state_next     = state_reg;
        lat_next       = lat_reg;
        agent_next     = agent_reg;
        cx_next        = cx_reg;
        cy_next        = cy_reg;
        nx_next        = nx_reg;
        ny_next        = ny_reg;
        under_next     = under_reg;
        nxt_old_next   = nxt_old_reg;
        done_next      = 3'b000;
        rejected_next  = 1'b0;
        ram_addr_next  = ram_addr_reg;
        ram_wren_next  = 1'b0;
        ram_wdata_next = ram_wdata_reg;

        case (state_reg)
            IDLE: begin
                if (req != 3'b000) begin
                    agent_next = grant;
                    cx_next    = in_cx;
                    cy_next    = in_cy;
                    nx_next    = in_nx;
                    ny_next    = in_ny;
                    if (!move_ok(in_cx, in_cy, in_nx, in_ny)) begin
                        state_next    = DONE;
                        done_next     = 3'b001 << grant;
                        rejected_next = 1'b1;
                    end else begin
                        state_next    = RD_NXT;
                        lat_next      = 2'd0;
                        ram_addr_next = in_ny;
                    end
                end
            end
            RD_NXT: begin
                if (lat_reg == LAT_LAST) begin
                    if (patch_old == T_WALL) begin
                        state_next    = DONE;
                        done_next     = 3'b001 << agent_reg;
                        rejected_next = 1'b1;
                    end else begin
                        state_next     = WR_NXT;
                        ram_wren_next  = 1'b1;
                        ram_wdata_next = patch_row;
                        nxt_old_next   = patch_old;
                    end
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end
            WR_NXT: begin
                state_next    = RD_CUR;
                lat_next      = 2'd0;
                ram_addr_next = cy_reg;
            end
            RD_CUR: begin
                if (lat_reg == LAT_LAST) begin
                    state_next     = WR_CUR;
                    ram_wren_next  = 1'b1;
                    ram_wdata_next = patch_row;
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end
            WR_CUR: begin
                state_next = DONE;
                done_next  = 3'b001 << agent_reg;
                // Commit the covered tile only now, after the old one was restored.
                if (agent_reg == G1)
                    under_next[0] = is_agent_code(nxt_old_reg) ? T_EMPTY : nxt_old_reg;
                else if (agent_reg == G2)
                    under_next[1] = is_agent_code(nxt_old_reg) ? T_EMPTY : nxt_old_reg;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            lat_reg       <= 2'd0;
            agent_reg     <= PAC;
            cx_reg        <= '0;
            cy_reg        <= '0;
            nx_reg        <= '0;
            ny_reg        <= '0;
            under_reg     <= {T_EMPTY, T_EMPTY};
            nxt_old_reg   <= T_EMPTY;
            done_reg      <= 3'b000;
            rejected_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wren_reg  <= 1'b0;
            ram_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            lat_reg       <= lat_next;
            agent_reg     <= agent_next;
            cx_reg        <= cx_next;
            cy_reg        <= cy_next;
            nx_reg        <= nx_next;
            ny_reg        <= ny_next;
            under_reg     <= under_next;
            nxt_old_reg   <= nxt_old_next;
            done_reg      <= done_next;
            rejected_reg  <= rejected_next;
            busy_reg      <= busy_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wren_reg  <= ram_wren_next;
            ram_wdata_reg <= ram_wdata_next;
        end
    end

    assign done      = done_reg;
    assign rejected  = rejected_reg;
    assign busy      = busy_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wren  = ram_wren_reg;
    assign ram_wdata = ram_wdata_reg;
endmodule

// File: tb/tb_map_row_rmw_writer.sv
// Directed bench for map_row_rmw_writer: RAM model, expected-done scoreboard
// with a decoupled monitor, and direct map/tile checks after each move.
module tb_map_row_rmw_writer;
    localparam int RD_LAT = 2;
    localparam int ROW_W  = 160;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [2:0]          req = 3'b000;
    logic [2:0][5:0]     cur_x = '0;
    logic [2:0][4:0]     cur_y = '0;
    logic [2:0][5:0]     nxt_x = '0;
    logic [2:0][4:0]     nxt_y = '0;
    logic [2:0]          done;
    logic                rejected;
    logic                busy;
    logic [4:0]          ram_addr;
    logic                ram_wren;
    logic [ROW_W-1:0]    ram_wdata;
    logic [ROW_W-1:0]    ram_rdata;

    map_row_rmw_writer #(.RD_LAT(RD_LAT)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .req       (req),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .nxt_x     (nxt_x),
        .nxt_y     (nxt_y),
        .done      (done),
        .rejected  (rejected),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Map RAM: q in a cycle reflects the address presented one cycle earlier,
    // so the row arrives in the last of the two read cycles; writes are seen next cycle.
    logic [ROW_W-1:0] mem [30];
    logic [4:0]       addr_d = '0;
    logic             bd_en = 1'b0;
    logic             bd_clr = 1'b0;
    logic [4:0]       bd_y = '0;
    logic [ROW_W-1:0] bd_row = '0;
    int               cyc = 0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        addr_d <= ram_addr;
        if (bd_clr) begin
            for (int i = 0; i < 30; i++) mem[i] <= '0;
        end else if (ram_wren) begin
            if (ram_addr < 5'd30) mem[ram_addr] <= ram_wdata;
        end else if (bd_en) begin
            mem[bd_y] <= bd_row;
        end
    end

    assign ram_rdata = (addr_d < 5'd30) ? mem[addr_d] : '0;

    typedef struct {
        logic [2:0] who;
        logic       rej;
        int         at;
        int         writes;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   wr_cnt = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    function automatic logic [3:0] tile(input int x, input int y);
        logic [ROW_W-1:0] r;
        r = mem[y];
        return r[ROW_W-1-4*x -: 4];
    endfunction

    task automatic check_tile(input string name, input int x, input int y, input int expv);
        check(name, int'(tile(x, y)), expv);
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (reset) begin
            wr_cnt = 0;
        end else begin
            if (ram_wren) wr_cnt = wr_cnt + 1;
            if (done != 3'b000) begin
                $display("txn done=%b rejected=%b cycle=%0d writes=%0d", done, rejected, cyc, wr_cnt);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_who", int'(done), int'(mon_e.who));
                    check("rejected", int'(rejected), int'(mon_e.rej));
                    check("done_cycle", cyc, mon_e.at);
                    check("write_count", wr_cnt, mon_e.writes);
                end
                wr_cnt = 0;
            end
        end
    end

    task automatic poke(input int x, input int y, input logic [3:0] code);
        @(negedge clk);
        bd_row = mem[y];
        bd_row[ROW_W-1-4*x -: 4] = code;
        bd_y   = 5'(y);
        bd_en  = 1'b1;
        @(negedge clk);
        bd_en  = 1'b0;
    endtask

    task automatic set_move(input int a, input int cx, input int cy, input int nx, input int ny);
        cur_x[a] = 6'(cx);
        cur_y[a] = 5'(cy);
        nxt_x[a] = 6'(nx);
        nxt_y[a] = 5'(ny);
    endtask

    task automatic expect_done(input logic [2:0] who, input logic rej, input int at, input int writes);
        exp_t e;
        e.who = who; e.rej = rej; e.at = at; e.writes = writes;
        exp_q.push_back(e);
    endtask

    // Drops each agent's req on its done, as a requester must.
    task automatic wait_idle(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done != 3'b000) req = req & ~done;
            if (req == 3'b000 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({"complete_", name}, int'(ok), 1);
        req = 3'b000;
    endtask

    // Single request: done expected 'lat' cycles after the acceptance edge.
    task automatic go(input string name, input logic [2:0] mask, input int lat,
                      input logic rej, input int writes);
        int c;
        @(negedge clk);
        c = cyc;
        req = mask;
        expect_done(mask, rej, c + lat, writes);
        wait_idle(name, 60);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        bd_clr = 1'b1;
        repeat (3) @(negedge clk);
        bd_clr = 1'b0;

        check("rst_done", int'(done), 0);
        check("rst_rejected", int'(rejected), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wren", int'(ram_wren), 0);
        check("rst_addr", int'(ram_addr), 0);
        check("rst_wdata_zero", int'(ram_wdata != '0), 0);
        reset = 1'b0;

        poke(20, 20, 4'd3); poke(21, 20, 4'd2); poke(22, 20, 4'd1);
        poke(16, 12, 4'd2); poke(16, 13, 4'd4);
        poke(0, 0, 4'd5);   poke(0, 1, 4'd2);

        // Pacman onto a pill.
        set_move(0, 20, 20, 21, 20);
        go("pac_pill", 3'b001, 7, 1'b0, 2);
        check_tile("pac_new_tile", 21, 20, 3);
        check_tile("pac_old_tile", 20, 20, 0);
        check_tile("pac_wall_kept", 22, 20, 1);

        // Ghost1 up onto a pill, then back: the pill reappears.
        set_move(1, 16, 13, 16, 12);
        go("g1_up", 3'b010, 7, 1'b0, 2);
        check_tile("g1_up_new", 16, 12, 4);
        check_tile("g1_up_old", 16, 13, 0);
        set_move(1, 16, 12, 16, 13);
        go("g1_back", 3'b010, 7, 1'b0, 2);
        check_tile("g1_back_new", 16, 13, 4);
        check_tile("g1_back_pill", 16, 12, 2);

        // Pacman into a wall.
        set_move(0, 21, 20, 22, 20);
        go("pac_wall", 3'b001, 3, 1'b1, 0);
        check_tile("wall_pac_stays", 21, 20, 3);
        check_tile("wall_unchanged", 22, 20, 1);

        // All three at once: served in priority order, 8 cycles apart.
        set_move(0, 21, 20, 21, 21);
        set_move(1, 16, 13, 17, 13);
        set_move(2, 0, 0, 0, 1);
        @(negedge clk);
        c = cyc;
        req = 3'b111;
        expect_done(3'b001, 1'b0, c + 7, 2);
        expect_done(3'b010, 1'b0, c + 15, 2);
        expect_done(3'b100, 1'b0, c + 23, 2);
        wait_idle("all_three", 100);
        check_tile("arb_pac_old", 21, 20, 0);
        check_tile("arb_pac_new", 21, 21, 3);
        check_tile("arb_g1_same_row_old", 16, 13, 0);
        check_tile("arb_g1_same_row_new", 17, 13, 4);
        check_tile("arb_g2_old", 0, 0, 0);
        check_tile("arb_g2_new", 0, 1, 5);

        // Ghost2 steps onto a pacman-coded tile: it must later restore EMPTY, not 3.
        poke(1, 1, 4'd3);
        set_move(2, 0, 1, 1, 1);
        go("g2_onto_agent", 3'b100, 7, 1'b0, 2);
        check_tile("g2_restores_pill", 0, 1, 2);
        check_tile("g2_on_agent_tile", 1, 1, 5);
        set_move(2, 1, 1, 2, 1);
        go("g2_leave_agent", 3'b100, 7, 1'b0, 2);
        check_tile("g2_sanitized_under", 1, 1, 0);
        check_tile("g2_new_pos", 2, 1, 5);

        // Immediate rejects.
        set_move(0, 39, 21, 40, 21);
        go("rej_range", 3'b001, 1, 1'b1, 0);
        set_move(0, 21, 21, 22, 22);
        go("rej_diag", 3'b001, 1, 1'b1, 0);
        set_move(0, 21, 21, 21, 21);
        go("rej_same", 3'b001, 1, 1'b1, 0);
        check_tile("rej_map_unchanged", 21, 21, 3);

        // Reset while WR_NXT is driving a write.
        set_move(0, 21, 21, 21, 22);
        @(negedge clk);
        req = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        check("wren_in_wr_nxt", int'(ram_wren), 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_wren", int'(ram_wren), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_addr", int'(ram_addr), 0);
        check("midrst_wdata_zero", int'(ram_wdata != '0), 0);
        req = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_tile("midrst_no_write_new", 21, 22, 0);
        check_tile("midrst_no_write_old", 21, 21, 3);
        go("after_reset", 3'b001, 7, 1'b0, 2);
        check_tile("after_reset_new", 21, 22, 3);
        check_tile("after_reset_old", 21, 21, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
